// File: rtl/reset_ctrl_pkg.sv
// Shared types and constants for the board reset path feeding the data-memory reset controller.
package reset_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    SWEEP      = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  localparam int DMEM_ADDR_W = 6;
  // One full reset-image sweep touches every word for two cycles.
  localparam int DMEM_RESET_SWEEP_CYCLES = 2 * (2 ** DMEM_ADDR_W);

  function automatic int counter_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if ($clog2(m) < 1) begin
      return 1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous board input, reset to 0.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; the oldest stage is the only one safe to use downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_bit};
    end
  end

  assign sync_bit = sync_r[STAGES-1];

endmodule

// File: rtl/reset_button_conditioner.sv
// Turns the raw reset pushbutton into a debounced, minimum-length reset request
// for the data-memory reset controller.
module reset_button_conditioner
  import reset_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MIN_HOLD_CYCLES = DMEM_RESET_SWEEP_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button_in,
  output logic       mem_reset_out,
  output logic       busy,
  output logic       sweep_done,
  output logic [7:0] sweep_count
);

  localparam int              CNT_W     = counter_width(DEBOUNCE_CYCLES, MIN_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD_CYCLES - 1);

  logic             btn_s;
  state_t           state_r;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next;
  logic             mem_next;
  logic             busy_next;
  logic             done_next;
  logic [7:0]       count_next;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_bit(button_in),
    .sync_bit (btn_s)
  );

  // State and shared counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
    end
  end

  // Next-state logic; the button is deliberately ignored while sweeping.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (btn_s) state_next = PRESS_DB;
        else       state_next = IDLE;
      end
      PRESS_DB: begin
        if (!btn_s)                 state_next = IDLE;
        else if (cnt_r == DB_LAST)  state_next = SWEEP;
        else                        state_next = PRESS_DB;
      end
      SWEEP: begin
        if (cnt_r == HOLD_LAST) state_next = HELD;
        else                    state_next = SWEEP;
      end
      HELD: begin
        if (!btn_s) state_next = RELEASE_DB;
        else        state_next = HELD;
      end
      RELEASE_DB: begin
        if (btn_s)                  state_next = HELD;
        else if (cnt_r == DB_LAST)  state_next = IDLE;
        else                        state_next = RELEASE_DB;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and counter next values, computed from the upcoming state so the flops line up with it.
  always_comb begin
    cnt_next   = CNT_ZERO;
    mem_next   = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    count_next = sweep_count;
    if (state_next != state_r) begin
      cnt_next = CNT_ZERO;
    end else if ((state_r == PRESS_DB) || (state_r == SWEEP) || (state_r == RELEASE_DB)) begin
      cnt_next = cnt_r + CNT_ONE;
    end else begin
      cnt_next = CNT_ZERO;
    end
    mem_next  = (state_next == SWEEP) || (state_next == HELD) || (state_next == RELEASE_DB);
    busy_next = (state_next != IDLE);
    done_next = (state_r == SWEEP) && (cnt_r == HOLD_LAST);
    if (done_next) begin
      count_next = sweep_count + 8'd1;
    end else begin
      count_next = sweep_count;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_reset_out <= 1'b0;
      busy          <= 1'b0;
      sweep_done    <= 1'b0;
      sweep_count   <= 8'd0;
    end else begin
      mem_reset_out <= mem_next;
      busy          <= busy_next;
      sweep_done    <= done_next;
      sweep_count   <= count_next;
    end
  end

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Self-checking bench for reset_button_conditioner against a run-length reference model.
module tb_reset_button_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int H = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       button_in;
  logic       mem_reset_out;
  logic       busy;
  logic       sweep_done;
  logic [7:0] sweep_count;

  reset_button_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .MIN_HOLD_CYCLES(H)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .button_in    (button_in),
    .mem_reset_out(mem_reset_out),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .sweep_count  (sweep_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 waits for D+1 consecutive pressed samples, mode 1 counts out
  // the hold time, mode 2 waits for D+1 consecutive released samples.
  int sync_q[$];
  int mode, run, timer, m_count, m_pulses;
  bit m_done;

  int cyc, rise_at, fall_at, done_at, obs_pulses, high_cnt, busy_seen, edge0, pulses0;
  logic prev_mem;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sync_q = {};
    for (int i = 0; i < S; i++) sync_q.push_back(0);
    mode = 0; run = 0; timer = 0; m_count = 0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    int s;
    s = sync_q[S-1];
    sync_q.push_front(int'(b));
    void'(sync_q.pop_back());
    m_done = 1'b0;
    case (mode)
      0: begin
        run = (s != 0) ? run + 1 : 0;
        if (run == D + 1) begin mode = 1; timer = H; run = 0; end
      end
      1: begin
        timer--;
        if (timer == 0) begin
          mode = 2; run = 0; m_done = 1'b1;
          m_count = (m_count + 1) % 256; m_pulses++;
        end
      end
      2: begin
        run = (s == 0) ? run + 1 : 0;
        if (run == D + 1) begin mode = 0; run = 0; end
      end
      default: mode = 0;
    endcase
  endtask

  task automatic step(input logic b);
    button_in = b;
    @(posedge clock);
    cyc++;
    model_edge(b);
    @(negedge clock);
    check("mem_reset_out", {7'd0, mem_reset_out}, {7'd0, (mode != 0)});
    check("busy", {7'd0, busy}, {7'd0, (mode != 0) || (run > 0)});
    check("sweep_done", {7'd0, sweep_done}, {7'd0, m_done});
    check("sweep_count", sweep_count, m_count[7:0]);
    if (mem_reset_out && !prev_mem) rise_at = cyc;
    if (!mem_reset_out && prev_mem) fall_at = cyc;
    prev_mem = mem_reset_out;
    if (sweep_done) begin obs_pulses++; done_at = cyc; end
    if (mem_reset_out) high_cnt++;
    if (busy) busy_seen = 1;
  endtask

  task automatic steps(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem"}, {7'd0, mem_reset_out}, 8'd0);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_done"}, {7'd0, sweep_done}, 8'd0);
    check({tag, "_count"}, sweep_count, 8'd0);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    prev_mem = 1'b0;
  endtask

  initial begin
    cyc = 0; m_pulses = 0; obs_pulses = 0; prev_mem = 1'b0;
    rise_at = 0; fall_at = 0; done_at = 0; high_cnt = 0; busy_seen = 0;
    button_in = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Clean press, held 40 cycles: rise after press+6, sweep_done after press+14.
    steps(1'b0, 9);
    edge0 = cyc + 1;
    steps(1'b1, 40);
    check("press_latency", 8'(rise_at - edge0), 8'(S + D));
    check("done_latency", 8'(done_at - edge0), 8'(S + D + H));
    edge0 = cyc + 1;
    steps(1'b0, 15);
    check("release_latency", 8'(fall_at - edge0), 8'(S + D));
    check("count_after_one", sweep_count, 8'd1);

    // 3-cycle glitch: busy pulses, no reset request.
    busy_seen = 0; high_cnt = 0;
    steps(1'b1, 3);
    steps(1'b0, 10);
    check("glitch_busy", 8'(busy_seen), 8'd1);
    check("glitch_no_mem", 8'(high_cnt), 8'd0);
    check("glitch_count", sweep_count, 8'd1);

    // Short 6-cycle press still gets a full sweep plus release debounce.
    high_cnt = 0; pulses0 = obs_pulses;
    steps(1'b1, 6);
    steps(1'b0, 30);
    check("short_high_min", {7'd0, (high_cnt >= H + D)}, 8'd1);
    check("short_one_done", 8'(obs_pulses - pulses0), 8'd1);

    // Release bounce while held.
    steps(1'b1, 25);
    steps(1'b0, 2);
    steps(1'b1, 5);
    check("bounce_mem_held", {7'd0, mem_reset_out}, 8'd1);
    edge0 = cyc + 1;
    steps(1'b0, 15);
    check("bounce_fall", 8'(fall_at - edge0), 8'(S + D));

    // Async reset mid-sweep, then a fresh sequence with the button still held.
    steps(1'b1, S + D + 3);
    check("pre_reset_sweep", {7'd0, mem_reset_out}, 8'd1);
    #2;
    apply_reset("midsweep");
    edge0 = cyc + 1;
    steps(1'b1, 30);
    check("rearm_latency", 8'(rise_at - edge0), 8'(S + D));
    check("rearm_count", sweep_count, 8'd1);
    steps(1'b0, 15);

    // Random bouncy button activity.
    for (int i = 0; i < 60; i++) begin
      steps(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    steps(1'b0, 30);

    // 256 full press/release cycles wrap the sweep counter.
    apply_reset("prewrap");
    pulses0 = obs_pulses;
    for (int i = 0; i < 256; i++) begin
      steps(1'b1, int'($urandom_range(1, 20)) + S + D);
      steps(1'b0, H + S + D + 8);
    end
    check("wrap_count", sweep_count, 8'd0);
    check("wrap_pulses", 8'((obs_pulses - pulses0) / 2), 8'd128);
    check("wrap_pulses_exact", {7'd0, ((obs_pulses - pulses0) == 256)}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
